// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and column-clamp helper for the 3x3 window controller.
package conv_pkg;

  localparam int PIX_W       = 8;
  localparam int NUM_LINES   = 4;
  localparam int KERNEL_ROWS = 3;
  localparam int WIN_W       = KERNEL_ROWS * KERNEL_ROWS * PIX_W;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Window columns past the right edge replicate the last pixel of the line.
  function automatic int clamp_col(int col, int off, int img_w);
    return (col + off > img_w - 1) ? img_w - 1 : col + off;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: single write port, three adjacent clamped pixels read combinationally.
module line_buffer #(
  parameter int IMG_W = 512,
  parameter int PIX_W = 8,
  localparam int AW   = $clog2(IMG_W)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic [AW-1:0]      rd_col,
  output logic [3*PIX_W-1:0] rd_data
);
  import conv_pkg::*;

  logic [PIX_W-1:0] mem [IMG_W];

  // Storage is deliberately not reset; the fill counter guards against stale lines.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < 3; k++) begin
      rd_data[k*PIX_W +: PIX_W] = mem[AW'(clamp_col(int'(rd_col), k, IMG_W))];
    end
  end

endmodule

// File: rtl/conv_window_controller.sv
// Buffers a raster pixel stream in four line buffers and issues one 3x3 window per cycle
// for each completed group of three lines.
module conv_window_controller #(
  parameter int IMG_W = 512,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   in_pixel_data,
  input  logic               in_pixel_valid,
  output logic [9*PIX_W-1:0] out_pixel_data,
  output logic               out_pixel_valid,
  output logic               out_line_done
);
  import conv_pkg::*;

  localparam int AW = $clog2(IMG_W);
  localparam int CW = $clog2(NUM_LINES * IMG_W + 1);
  localparam int SW = $clog2(NUM_LINES);
  localparam logic [CW-1:0] FULL     = CW'(NUM_LINES * IMG_W);
  localparam logic [CW-1:0] THRESH   = CW'(KERNEL_ROWS * IMG_W);
  localparam logic [AW-1:0] LAST_COL = AW'(IMG_W - 1);

  state_t             state, state_nxt;
  logic [AW-1:0]      wr_cnt, rd_cnt;
  logic [SW-1:0]      wr_sel, rd_sel;
  logic [CW-1:0]      total_cnt;
  logic               wr_accept, rd_issue, rd_last;
  logic [3*PIX_W-1:0] lb_rd [NUM_LINES];
  logic [9*PIX_W-1:0] window;

  assign wr_accept = in_pixel_valid && (total_cnt != FULL);
  assign rd_last   = (rd_cnt == LAST_COL);

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_lb
    line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb (
      .clk     (clk),
      .wr_en   (wr_accept && (wr_sel == SW'(g))),
      .wr_addr (wr_cnt),
      .wr_data (in_pixel_data),
      .rd_col  (rd_cnt),
      .rd_data (lb_rd[g])
    );
  end

  // Row 0 of the window is the oldest buffered line, at rd_sel.
  always_comb begin
    window = '0;
    for (int r = 0; r < KERNEL_ROWS; r++) begin
      window[r*3*PIX_W +: 3*PIX_W] = lb_rd[SW'(rd_sel + SW'(r))];
    end
  end

  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    case (state)
      IDLE: if (total_cnt >= THRESH) state_nxt = READ;
      READ: begin
        rd_issue = 1'b1;
        if (rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wr_cnt          <= '0;
      wr_sel          <= '0;
      rd_cnt          <= '0;
      rd_sel          <= '0;
      total_cnt       <= '0;
      out_pixel_data  <= '0;
      out_pixel_valid <= 1'b0;
      out_line_done   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (wr_accept) begin
        if (wr_cnt == LAST_COL) begin
          wr_cnt <= '0;
          wr_sel <= wr_sel + 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      // A write and a window read in the same cycle cancel out.
      if (wr_accept && !rd_issue)      total_cnt <= total_cnt + 1'b1;
      else if (!wr_accept && rd_issue) total_cnt <= total_cnt - 1'b1;

      if (rd_issue) begin
        if (rd_last) begin
          rd_cnt <= '0;
          rd_sel <= rd_sel + 1'b1;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
        out_pixel_data <= window;
      end

      out_pixel_valid <= rd_issue;
      out_line_done   <= rd_issue && rd_last;
    end
  end

endmodule

// File: tb/tb_conv_window_controller.sv
// Self-checking bench for conv_window_controller with IMG_W = 8: directed table plus
// randomized streaming against a line-oriented reference model.
`timescale 1ns/1ps
module tb_conv_window_controller;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_pixel_data = '0;
  logic        in_pixel_valid = 1'b0;
  logic [71:0] out_pixel_data;
  logic        out_pixel_valid;
  logic        out_line_done;

  int tests = 0;
  int fails = 0;

  conv_window_controller #(.IMG_W(W), .PIX_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_pixel_data   (in_pixel_data),
    .in_pixel_valid  (in_pixel_valid),
    .out_pixel_data  (out_pixel_data),
    .out_pixel_valid (out_pixel_valid),
    .out_line_done   (out_line_done)
  );

  always #5 clk = ~clk;

  // Reference model: accepted pixels are kept by stream index; burst n reads lines n..n+2.
  logic [7:0]  hist [4096];
  int          m_acc = 0, m_lines = 0, m_total = 0, m_rd = 0;
  bit          m_read = 1'b0;
  logic [71:0] exp_data = '0;
  bit          exp_valid = 1'b0, exp_done = 1'b0;

  function automatic logic [71:0] model_window(int line0, int col);
    logic [71:0] w;
    int c;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        c = (col + k > W - 1) ? W - 1 : col + k;
        w[(3*r + k)*8 +: 8] = hist[((line0 + r)*W + c) % 4096];
      end
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit issue, acc;
    int prev_total;
    if (!rst_n) begin
      m_acc = 0; m_lines = 0; m_total = 0; m_rd = 0; m_read = 1'b0;
      exp_data = '0; exp_valid = 1'b0; exp_done = 1'b0;
    end else begin
      prev_total = m_total;
      issue      = m_read;
      acc        = in_pixel_valid && (m_total < 4*W);
      exp_valid  = issue;
      exp_done   = issue && (m_rd == W - 1);
      if (issue) exp_data = model_window(m_lines, m_rd);
      if (acc) begin
        hist[m_acc % 4096] = in_pixel_data;
        m_acc++;
      end
      m_total = m_total + int'(acc) - int'(issue);
      if (issue) begin
        if (m_rd == W - 1) begin
          m_read = 1'b0; m_rd = 0; m_lines++;
        end else begin
          m_rd++;
        end
      end else if (prev_total >= 3*W) begin
        m_read = 1'b1;
      end
    end
  end

  logic [71:0] obs_win [$];
  int          done_cnt = 0;

  task automatic compare(string name, logic [71:0] act, logic [71:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      if (fails <= 40) $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic checkOutput();
    compare("out_pixel_valid", 72'(out_pixel_valid), 72'(exp_valid));
    compare("out_line_done", 72'(out_line_done), 72'(exp_done));
    compare("out_pixel_data", out_pixel_data, exp_data);
    compare("total_cnt", 72'(dut.total_cnt), 72'(m_total));
    compare("wr_cnt", 72'(dut.wr_cnt), 72'(m_acc % W));
    if (out_pixel_valid) obs_win.push_back(out_pixel_data);
    if (out_line_done) done_cnt++;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    @(negedge clk);
    checkOutput();
    in_pixel_valid = v;
    in_pixel_data  = d;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    in_pixel_valid = 1'b1;
    in_pixel_data  = 8'h5A;
    repeat (3) begin
      applyStimulus(1'b1, 8'h55);
      compare("rst_out_valid", 72'(out_pixel_valid), 72'd0);
      compare("rst_out_data", out_pixel_data, 72'd0);
      compare("rst_line_done", 72'(out_line_done), 72'd0);
    end
    rst_n = 1'b1;
    in_pixel_valid = 1'b0;
    obs_win.delete();
    done_cnt = 0;
  endtask

  function automatic logic [71:0] win9(int a0, int a1, int a2, int a3, int a4,
                                       int a5, int a6, int a7, int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [7:0] pat(int i);
    return 8'(16*(i / W) + i % W);
  endfunction

  typedef struct {
    int          n_pix;
    int          exp_valid;
    int          exp_done;
    logic [71:0] exp_first;
    logic [71:0] exp_last;
    logic [71:0] exp_second;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int guard;
    int exp_wr;
    int pct;

    vecs[0] = '{23, 0, 0, '0, '0, '0};
    vecs[1] = '{24, 8, 1, win9(0,1,2,16,17,18,32,33,34), win9(7,7,7,23,23,23,39,39,39), '0};
    vecs[2] = '{40, 24, 3, win9(0,1,2,16,17,18,32,33,34), win9(7,7,7,23,23,23,39,39,39),
                win9(16,17,18,32,33,34,48,49,50)};

    // Directed fill / burst / streaming vectors.
    for (int t = 0; t < 3; t++) begin
      doReset();
      for (int i = 0; i < vecs[t].n_pix; i++) applyStimulus(1'b1, pat(i));
      repeat (40) applyStimulus(1'b0, 8'h00);
      compare($sformatf("vec%0d_valid_count", t), 72'(obs_win.size()), 72'(vecs[t].exp_valid));
      compare($sformatf("vec%0d_done_count", t), 72'(done_cnt), 72'(vecs[t].exp_done));
      if (vecs[t].exp_valid >= 8) begin
        compare($sformatf("vec%0d_first_window", t), obs_win[0], vecs[t].exp_first);
        compare($sformatf("vec%0d_last_window", t), obs_win[7], vecs[t].exp_last);
      end
      if (vecs[t].exp_valid >= 16) begin
        compare($sformatf("vec%0d_second_burst", t), obs_win[8], vecs[t].exp_second);
      end
    end

    // Reset in the middle of a burst discards all buffered lines.
    doReset();
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, 8'(8'hC0 + i));
    guard = 0;
    while (obs_win.size() < 4 && guard < 60) begin
      applyStimulus(1'b0, 8'h00);
      guard++;
    end
    compare("midrst_reached_4th_window", 72'(obs_win.size()), 72'd4);
    rst_n = 1'b0;
    #1;
    compare("midrst_valid_drop", 72'(out_pixel_valid), 72'd0);
    applyStimulus(1'b0, 8'h00);
    rst_n = 1'b1;
    obs_win.delete();
    done_cnt = 0;
    for (int i = 0; i < 23; i++) applyStimulus(1'b1, pat(i));
    repeat (20) applyStimulus(1'b0, 8'h00);
    compare("midrst_no_window_23", 72'(obs_win.size()), 72'd0);
    applyStimulus(1'b1, pat(23));
    repeat (20) applyStimulus(1'b0, 8'h00);
    compare("midrst_burst_len", 72'(obs_win.size()), 72'd8);
    compare("midrst_first_window", obs_win[0], win9(0,1,2,16,17,18,32,33,34));

    // Continuous streaming until the buffers are full; the next write must be dropped.
    doReset();
    guard = 0;
    while (m_total != 4*W && guard < 600) begin
      applyStimulus(1'b1, 8'($urandom));
      guard++;
    end
    compare("full_reached", 72'(m_total), 72'(4*W));
    exp_wr = m_acc % W;
    applyStimulus(1'b1, 8'($urandom));
    compare("full_wr_cnt_held", 72'(dut.wr_cnt), 72'(exp_wr));

    // Randomized streaming at several input densities.
    doReset();
    for (int p = 0; p < 3; p++) begin
      pct = (p == 0) ? 30 : (p == 1) ? 70 : 100;
      repeat (600) applyStimulus(1'($urandom_range(0, 99) < pct), 8'($urandom));
    end
    doReset();
    repeat (400) applyStimulus(1'($urandom_range(0, 99) < 85), 8'($urandom));
    repeat (30) applyStimulus(1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
